// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RV32 control FSM
// The state register is the only storage; every output is decoded from it.
module mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUctrl,
  output logic [2:0] ImmSrc,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_EXEI   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t cur, nxt;

  logic [3:0] arith_op;
  logic       f7_ok;
  logic [3:0] br_op;
  logic       br_take;
  logic       br_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Register-register and immediate ALU decode; only EXER may pick SUB.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000: arith_op = (cur == S_EXER && funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  assign f7_ok = (funct7 == 7'h00) || (funct7 == 7'h20);

  always_comb begin
    br_op   = ALU_ADD;
    br_take = 1'b0;
    br_bad  = 1'b0;
    case (funct3)
      3'b000: begin br_op = ALU_SUB;  br_take = Zero;  end
      3'b001: begin br_op = ALU_SUB;  br_take = ~Zero; end
      3'b100: begin br_op = ALU_SLT;  br_take = ~Zero; end
      3'b101: begin br_op = ALU_SLT;  br_take = Zero;  end
      3'b110: begin br_op = ALU_SLTU; br_take = ~Zero; end
      3'b111: begin br_op = ALU_SLTU; br_take = Zero;  end
      default: br_bad = 1'b1;
    endcase
  end

  always_comb begin
    nxt       = cur;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUctrl   = ALU_ADD;
    ImmSrc    = IMM_I;
    case (cur)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures OldPC+imm: the branch target, or the JAL target.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_RTYPE:          nxt = S_EXER;
          OP_ITYPE:          nxt = S_EXEI;
          OP_BRANCH:         nxt = S_BRANCH;
          OP_JAL:            nxt = S_JAL;
          default:           nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        nxt     = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        nxt       = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_EXER: begin
        ALUSrcA = 2'b10;
        ALUctrl = arith_op;
        nxt     = f7_ok ? S_ALUWB : S_TRAP;
      end
      S_EXEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUctrl = arith_op;
        nxt     = (funct3 == 3'b101 && !f7_ok) ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        nxt      = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUctrl = br_op;
        PCWrite = br_take;
        nxt     = br_bad ? S_TRAP : S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link OldPC+4.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        nxt     = S_ALUWB;
      end
      default: nxt = S_TRAP;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign state   = cur;
  assign illegal = (cur == S_TRAP);

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed vector bench for mc_controller
module tb_mc_controller;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUctrl;
  logic [2:0] ImmSrc;
  logic [3:0] state;
  logic       illegal;

  int errors = 0;
  int checks = 0;

  mc_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .state(state),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    logic       mr;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];

  logic [23:0] outs;
  assign outs = {state, PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, illegal};

  task automatic r(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                   input logic z, input logic m, input logic [3:0] st,
                   input logic pcw, input logic adr, input logic mrd, input logic mwr,
                   input logic irw, input logic rgw, input logic [1:0] rs,
                   input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] alu,
                   input logic [2:0] imm, input logic ill);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = m;
    v.exp = {st, pcw, adr, mrd, mwr, irw, rgw, rs, sa, sb, alu, imm, ill};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic m);
    op = o; funct3 = f3; funct7 = f7; Zero = z; mem_ready = m;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset taken mid-cycle, then released on a falling edge.
  task automatic do_reset(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check({name, "_state"}, 32'(state), 32'd0);
    check({name, "_illegal"}, 32'(illegal), 32'd0);
    check({name, "_strobes"}, 32'({PCWrite, MemRead, MemWrite, IRWrite, RegWrite}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({name, "_post_fetch"}, 32'({state, MemRead}), 32'h01);
  endtask

  initial begin
    rst = 1'b1;
    drive(7'h33, 3'd0, 7'h00, L, H);

    // add x3,x1,x2
    r(7'h33,3'd0,7'h00,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h33,3'd0,7'h00,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h33,3'd0,7'h00,L,H, 4'd6,L,L,L,L,L,L,2'd0,2'd2,2'd0,4'd0,3'd0,L);
    r(7'h33,3'd0,7'h00,L,H, 4'd8,L,L,L,L,L,H,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    // sub with one fetch wait cycle
    r(7'h33,3'd0,7'h20,L,L, 4'd0,L,L,H,L,L,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h33,3'd0,7'h20,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h33,3'd0,7'h20,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h33,3'd0,7'h20,L,H, 4'd6,L,L,L,L,L,L,2'd0,2'd2,2'd0,4'd1,3'd0,L);
    r(7'h33,3'd0,7'h20,L,H, 4'd8,L,L,L,L,L,H,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    // sra
    r(7'h33,3'd5,7'h20,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h33,3'd5,7'h20,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h33,3'd5,7'h20,L,H, 4'd6,L,L,L,L,L,L,2'd0,2'd2,2'd0,4'd7,3'd0,L);
    r(7'h33,3'd5,7'h20,L,H, 4'd8,L,L,L,L,L,H,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    // sltu
    r(7'h33,3'd3,7'h00,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h33,3'd3,7'h00,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h33,3'd3,7'h00,L,H, 4'd6,L,L,L,L,L,L,2'd0,2'd2,2'd0,4'd9,3'd0,L);
    r(7'h33,3'd3,7'h00,L,H, 4'd8,L,L,L,L,L,H,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    // srai
    r(7'h13,3'd5,7'h20,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h13,3'd5,7'h20,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h13,3'd5,7'h20,L,H, 4'd7,L,L,L,L,L,L,2'd0,2'd2,2'd1,4'd7,3'd0,L);
    r(7'h13,3'd5,7'h20,L,H, 4'd8,L,L,L,L,L,H,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    // addi whose immediate top bits look like 0x20: still ADD
    r(7'h13,3'd0,7'h20,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h13,3'd0,7'h20,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h13,3'd0,7'h20,L,H, 4'd7,L,L,L,L,L,L,2'd0,2'd2,2'd1,4'd0,3'd0,L);
    r(7'h13,3'd0,7'h20,L,H, 4'd8,L,L,L,L,L,H,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    // slli with odd funct7: not checked, no trap
    r(7'h13,3'd1,7'h7f,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h13,3'd1,7'h7f,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h13,3'd1,7'h7f,L,H, 4'd7,L,L,L,L,L,L,2'd0,2'd2,2'd1,4'd5,3'd0,L);
    r(7'h13,3'd1,7'h7f,L,H, 4'd8,L,L,L,L,L,H,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    // lw with three MEMRD wait cycles
    r(7'h03,3'd2,7'h00,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h03,3'd2,7'h00,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h03,3'd2,7'h00,L,H, 4'd2,L,L,L,L,L,L,2'd0,2'd2,2'd1,4'd0,3'd0,L);
    r(7'h03,3'd2,7'h00,L,L, 4'd3,L,H,H,L,L,L,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    r(7'h03,3'd2,7'h00,L,L, 4'd3,L,H,H,L,L,L,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    r(7'h03,3'd2,7'h00,L,L, 4'd3,L,H,H,L,L,L,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    r(7'h03,3'd2,7'h00,L,H, 4'd3,L,H,H,L,L,L,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    r(7'h03,3'd2,7'h00,L,H, 4'd4,L,L,L,L,L,H,2'd1,2'd0,2'd0,4'd0,3'd0,L);
    // sw with one wait cycle
    r(7'h23,3'd2,7'h00,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h23,3'd2,7'h00,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h23,3'd2,7'h00,L,H, 4'd2,L,L,L,L,L,L,2'd0,2'd2,2'd1,4'd0,3'd2,L);
    r(7'h23,3'd2,7'h00,L,L, 4'd5,L,H,L,H,L,L,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    r(7'h23,3'd2,7'h00,L,H, 4'd5,L,H,L,H,L,L,2'd0,2'd0,2'd0,4'd0,3'd0,L);
    // bne, Zero=1: not taken
    r(7'h63,3'd1,7'h00,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h63,3'd1,7'h00,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h63,3'd1,7'h00,H,H, 4'd9,L,L,L,L,L,L,2'd0,2'd2,2'd0,4'd1,3'd0,L);
    // bne, Zero=0: taken
    r(7'h63,3'd1,7'h00,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h63,3'd1,7'h00,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h63,3'd1,7'h00,L,H, 4'd9,H,L,L,L,L,L,2'd0,2'd2,2'd0,4'd1,3'd0,L);
    // bge, Zero=1: taken
    r(7'h63,3'd5,7'h00,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h63,3'd5,7'h00,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h63,3'd5,7'h00,H,H, 4'd9,H,L,L,L,L,L,2'd0,2'd2,2'd0,4'd8,3'd0,L);
    // bltu, Zero=1: not taken
    r(7'h63,3'd6,7'h00,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h63,3'd6,7'h00,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd3,L);
    r(7'h63,3'd6,7'h00,H,H, 4'd9,L,L,L,L,L,L,2'd0,2'd2,2'd0,4'd9,3'd0,L);
    // jal
    r(7'h6f,3'd0,7'h00,L,H, 4'd0,H,L,H,L,H,L,2'd2,2'd0,2'd2,4'd0,3'd0,L);
    r(7'h6f,3'd0,7'h00,L,H, 4'd1,L,L,L,L,L,L,2'd0,2'd1,2'd1,4'd0,3'd5,L);
    r(7'h6f,3'd0,7'h00,L,H, 4'd10,H,L,L,L,L,L,2'd0,2'd1,2'd2,4'd0,3'd0,L);
    r(7'h6f,3'd0,7'h00,L,H, 4'd8,L,L,L,L,L,H,2'd0,2'd0,2'd0,4'd0,3'd0,L);

    // Reset held with mem_ready high: FETCH but no strobes.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    check("reset_strobes", 32'({PCWrite, MemRead, MemWrite, IRWrite, RegWrite}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].mr);
      #1;
      check($sformatf("row%0d", i), 32'(outs), 32'(tbl[i].exp));
      tick();
    end

    // R-type with funct7 0x01 traps after EXER.
    drive(7'h33, 3'd0, 7'h01, L, H);
    tick(); tick();
    check("exer_bad_f7_state", 32'(state), 32'd6);
    tick();
    check("exer_bad_f7_trap", 32'({state, illegal}), 32'h17);
    do_reset("rst_after_exer_trap");

    // Reserved branch funct3 010: no PC write, then TRAP.
    drive(7'h63, 3'd2, 7'h00, H, H);
    tick(); tick();
    #1;
    check("br010_pcwrite", 32'({state, PCWrite}), 32'h12);
    tick();
    check("br010_trap", 32'({state, illegal}), 32'h17);
    do_reset("rst_after_br_trap");

    // srli with funct7 0x01 traps from EXEI.
    drive(7'h13, 3'd5, 7'h01, L, H);
    tick(); tick(); tick();
    check("exei_bad_f7_trap", 32'({state, illegal}), 32'h17);
    do_reset("rst_after_exei_trap");

    // Unknown opcode: TRAP is sticky for 10 cycles, memory idle.
    drive(7'h00, 3'd0, 7'h00, L, H);
    tick(); tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("trap_hold%0d", c), 32'({state, illegal, MemRead, IRWrite, PCWrite}), 32'hB8);
      tick();
    end
    do_reset("rst_trap");

    // Store waiting in MEMWR, aborted by an asynchronous reset.
    drive(7'h23, 3'd2, 7'h00, L, H);
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    #1;
    check("memwr_wait", 32'({state, MemWrite}), 32'hB);
    do_reset("rst_memwr");

    // Load waiting in MEMRD, aborted by an asynchronous reset.
    drive(7'h03, 3'd2, 7'h00, L, H);
    tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    #1;
    check("memrd_wait", 32'({state, MemRead}), 32'h7);
    do_reset("rst_memrd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
REQ-002 The block SHALL have these inputs:
  op  in  7  instruction[6:0], from the instruction register
  funct3  in  3  instruction[14:12]
  funct7  in  7  instruction[31:25]
  Zero  in  1  ALU zero flag, same cycle
  mem_ready  in  1  memory access complete this cycle
REQ-003 The block SHALL have these outputs:
  PCWrite  out  1  load PC
  AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
  MemRead  out  1  memory read request
  MemWrite  out  1  memory write request
  IRWrite  out  1  load IR and OldPC
  RegWrite  out  1  register-file write
  ResultSrc  out  2  result select: 00 = ALUOut reg, 01 = mem data, 10 = ALU result
  ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
  ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4
  ALUctrl  out  4  ALU operation
  ImmSrc  out  3  immediate format
  state  out  4  current state
  illegal  out  1  sticky trap flag

Function
REQ-004 ALUctrl encoding SHALL be: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-005 ImmSrc encoding SHALL be: I 000, S 010, B 011, U 100, J 101.
REQ-006 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXER 6, EXEI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11. The state register SHALL be the only sequential storage.
REQ-007 Every output not listed for a state SHALL be 0. All outputs SHALL be Moore outputs of the state, except PCWrite in FETCH and BRANCH and the mem_ready-gated strobes.
REQ-008 FETCH: MemRead = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUctrl = ADD, ResultSrc = 10. IRWrite and PCWrite SHALL equal mem_ready. The FSM SHALL hold in FETCH while mem_ready = 0 and go to DECODE when mem_ready = 1.
REQ-009 DECODE: ALUSrcA = 01, ALUSrcB = 01, ImmSrc = B, ALUctrl = ADD (precomputes the branch target). Next state by op:
  0000011 or 0100011 -> MEMADR
  0110011 -> EXER
  0010011 -> EXEI
  1100011 -> BRANCH
  1101111 -> JAL
  any other op -> TRAP
REQ-010 MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUctrl = ADD, ImmSrc = I for loads and S for stores. Next state is MEMRD for loads and MEMWR for stores.
REQ-011 MEMRD: AdrSrc = 1, MemRead = 1. The FSM SHALL hold until mem_ready = 1, then go to MEMWB.
REQ-012 MEMWB: ResultSrc = 01, RegWrite = 1, then FETCH.
REQ-013 MEMWR: AdrSrc = 1, MemWrite = 1 held until mem_ready = 1, then FETCH.
REQ-014 EXER: ALUSrcA = 10, ALUSrcB = 00. ALUctrl SHALL decode from funct3/funct7 per REQ-004. funct7 = 0x20 SHALL select SUB for funct3 000 and SRA for funct3 101.
REQ-015 EXEI: ALUSrcA = 10, ALUSrcB = 01, ImmSrc = I. funct7 SHALL be used only for funct3 101. ADDI SHALL never decode as SUB.
REQ-016 An EXER or EXEI funct7 other than 0x00/0x20 where funct7 is checked SHALL go to TRAP; otherwise the next state is ALUWB.
REQ-017 ALUWB: ResultSrc = 00, RegWrite = 1, then FETCH.
REQ-018 BRANCH: ALUSrcA = 10, ALUSrcB = 00, ResultSrc = 00, then FETCH. PCWrite by funct3:
  BEQ 000: SUB, PCWrite = Zero
  BNE 001: SUB, PCWrite = ~Zero
  BLT 100: SLT, PCWrite = ~Zero
  BGE 101: SLT, PCWrite = Zero
  BLTU 110: SLTU, PCWrite = ~Zero
  BGEU 111: SLTU, PCWrite = Zero
  funct3 010 or 011: no PCWrite, go to TRAP
REQ-019 JAL: two-cycle sequence. Cycle 1: ALUSrcA = 01, ALUSrcB = 10, ALUctrl = ADD. Cycle 2 (ALUWB) SHALL write the link value. DECODE SHALL already have formed OldPC+imm(J) in ALUOut; ImmSrc = J in DECODE when op = JAL. PCWrite = 1 with ResultSrc = 00 in the JAL state.
REQ-020 TRAP: illegal = 1, all strobes 0. The FSM SHALL remain in TRAP until rst.

Reset
REQ-021 rst asserted SHALL immediately set state = FETCH and illegal = 0, independent of clk. While rst is high, all strobes SHALL be 0, including the FETCH MemRead.
REQ-022 rst asserted mid-access (MEMRD/MEMWR/FETCH wait) SHALL abort the access. The first post-reset cycle SHALL be FETCH with MemRead = 1.

Verification
REQ-023 add x3,x1,x2 with mem_ready = 1 -> states 0,1,6,8,0; ALUctrl = 0000 in EXER; RegWrite = 1 only in ALUWB.
REQ-024 lw with mem_ready low for 3 MEMRD cycles -> MEMRD held exactly 4 cycles, then MEMWB with ResultSrc = 01 and RegWrite = 1.
REQ-025 bne with Zero = 1 -> PCWrite = 0 in BRANCH; with Zero = 0 -> PCWrite = 1; bge with SLT and Zero = 1 -> PCWrite = 1.
REQ-026 srai (funct3 101, funct7 0x20) -> ALUctrl = 0111; op = 0000000 -> TRAP, illegal = 1 held for 10 cycles.
REQ-027 rst pulsed asynchronously mid-MEMWR -> MemWrite drops before the next clk edge; state = 0 after release.
